spectrum_vram_scheduler: RTL and testbench

Sequences per-bin spectrum magnitudes into the VideoRAM write port that feeds the VGA bar renderer. It accepts one magnitude per FFT bin over a valid/ready handshake, then scales, clamps and peak-hold-decays each value. Each bin is expanded into a run of column writes (one bar, optional gap column), and the block flags end of frame. It drives the VRAM write address, data and enable from the same clock that the block runs on.

---
 rtl/spectrum_vram_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_spectrum_vram_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_vram_scheduler.sv
// spectrum_vram_scheduler
// Takes one FFT-bin magnitude at a time, turns it into a clamped,
// peak-held bar height, and writes that bar as a run of VRAM columns.
// A frame ends on the bin flagged binLast; frameDone pulses afterwards.

module spectrum_vram_scheduler #(
  parameter int NUM_BINS     = 64,
  parameter int COLS_PER_BIN = 10,
  parameter int MAG_SHIFT    = 6,
  parameter int MAX_HEIGHT   = 511,
  parameter int DECAY        = 4,
  parameter int GAP          = 1
) (
  input  logic        inClock,
  input  logic        rstN,
  input  logic        binValid,
  output logic        binReady,
  input  logic [15:0] binData,
  input  logic        binLast,
  output logic        vramWren,
  output logic [9:0]  vramWriteAddr,
  output logic [9:0]  vramInData,
  output logic        frameDone,
  output logic        overflow
);

  // idx must be able to hold NUM_BINS itself (the saturated "frame full" value)
  localparam int IDX_W = $clog2(NUM_BINS + 1);
  localparam int SEL_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int K_W   = (COLS_PER_BIN > 1) ? $clog2(COLS_PER_BIN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [K_W-1:0]   k_q;
  logic [15:0]      mag_q;
  logic             last_q;
  logic [9:0]       hold_q;
  logic [9:0]       peak_q [NUM_BINS];

  logic             ready_q;
  logic             wren_q;
  logic [9:0]       addr_q;
  logic [9:0]       data_q;
  logic             done_q;
  logic             ovf_q;

  logic [SEL_W-1:0] sel_s;
  logic [15:0]      shifted_s;
  logic [9:0]       height_s;
  logic [9:0]       peak_cur_s;
  logic [9:0]       decayed_s;
  logic [9:0]       new_peak_d;
  logic [9:0]       base_addr_s;
  logic             frame_full_s;
  logic             last_col_s;

  // The final column of a bin is blanked when the separator gap is enabled
  function automatic logic is_gap(input logic [K_W-1:0] k);
    return (GAP != 0) && (k == K_W'(COLS_PER_BIN - 1));
  endfunction

  assign binReady      = ready_q;
  assign vramWren      = wren_q;
  assign vramWriteAddr = addr_q;
  assign vramInData    = data_q;
  assign frameDone     = done_q;
  assign overflow      = ovf_q;

  // Height / decay / peak-hold arithmetic used in the CALC cycle
  always_comb begin
    sel_s        = idx_q[SEL_W-1:0];
    shifted_s    = mag_q >> MAG_SHIFT;
    height_s     = 10'd0;
    decayed_s    = 10'd0;
    new_peak_d   = 10'd0;
    peak_cur_s   = peak_q[sel_s];
    base_addr_s  = 10'(int'(idx_q) * COLS_PER_BIN);
    frame_full_s = (idx_q == IDX_W'(NUM_BINS));
    last_col_s   = (k_q == K_W'(COLS_PER_BIN - 1));
    if (shifted_s > 16'(MAX_HEIGHT)) begin
      height_s = 10'(MAX_HEIGHT);
    end else begin
      height_s = shifted_s[9:0];
    end
    if (peak_cur_s >= 10'(DECAY)) begin
      decayed_s = peak_cur_s - 10'(DECAY);
    end else begin
      decayed_s = 10'd0;
    end
    if (height_s > decayed_s) begin
      new_peak_d = height_s;
    end else begin
      new_peak_d = decayed_s;
    end
  end

  // Scheduler FSM with registered handshake and VRAM outputs
  always_ff @(posedge inClock or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      k_q     <= '0;
      mag_q   <= 16'd0;
      last_q  <= 1'b0;
      hold_q  <= 10'd0;
      for (int i = 0; i < NUM_BINS; i++) begin
        peak_q[i] <= 10'd0;
      end
      ready_q <= 1'b1;
      wren_q  <= 1'b0;
      addr_q  <= 10'd0;
      data_q  <= 10'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (binValid && ready_q) begin
            if (frame_full_s) begin
              // Bin beyond the frame: drop it, but still honour its last flag
              ovf_q <= 1'b1;
              if (binLast) begin
                ready_q <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              mag_q   <= binData;
              last_q  <= binLast;
              ready_q <= 1'b0;
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          peak_q[sel_s] <= new_peak_d;
          hold_q        <= new_peak_d;
          k_q           <= '0;
          wren_q        <= 1'b1;
          addr_q        <= base_addr_s;
          data_q        <= is_gap(K_W'(0)) ? 10'd0 : new_peak_d;
          state_q       <= WRITE;
        end
        WRITE: begin
          if (last_col_s) begin
            wren_q <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Only reachable for idx < NUM_BINS, so idx saturates at NUM_BINS
              idx_q   <= idx_q + IDX_W'(1);
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            k_q    <= k_q + K_W'(1);
            addr_q <= addr_q + 10'd1;
            data_q <= is_gap(k_q + K_W'(1)) ? 10'd0 : hold_q;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          idx_q   <= '0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          wren_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_vram_scheduler.sv
// Bench for spectrum_vram_scheduler: a transaction-level model predicts
// every cycle's outputs; directed frames add literal expectations.

module tb_spectrum_vram_scheduler;

  localparam int NB  = 64;
  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        binValid = 1'b0;
  logic [15:0] binData = 16'd0;
  logic        binLast = 1'b0;
  logic        binReady;
  logic        vramWren;
  logic [9:0]  vramWriteAddr;
  logic [9:0]  vramInData;
  logic        frameDone;
  logic        overflow;

  spectrum_vram_scheduler dut (
    .inClock      (clk),
    .rstN         (rstN),
    .binValid     (binValid),
    .binReady     (binReady),
    .binData      (binData),
    .binLast      (binLast),
    .vramWren     (vramWren),
    .vramWriteAddr(vramWriteAddr),
    .vramInData   (vramInData),
    .frameDone    (frameDone),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int peak_m [NB];
  int idx_m = 0;
  int ready_at = 0;
  int ovf_from = -1;
  int last_acc = 0;
  bit exp_wren [int];
  int exp_addr [int];
  int exp_data [int];
  bit exp_fd   [int];

  // observation logs used by the literal checks
  int wr_addr_q [$];
  int wr_data_q [$];
  int wr_cyc_q  [$];
  int fd_count = 0;
  int rise_cyc = 0;
  bit prev_ready = 1'b1;

  function automatic int bar_height(input int mag);
    int h;
    h = mag / 64;
    return (h > 511) ? 511 : h;
  endfunction

  function automatic int get_a(input int i);
    return (wr_addr_q.size() > i) ? wr_addr_q[i] : -1;
  endfunction

  function automatic int get_d(input int i);
    return (wr_data_q.size() > i) ? wr_data_q[i] : -1;
  endfunction

  // per-cycle compare against the model, then let the model see this cycle's handshake
  always @(negedge clk) begin
    if (!rstN) begin
      foreach (peak_m[i]) peak_m[i] = 0;
      idx_m = 0;
      ready_at = 0;
      ovf_from = -1;
      exp_wren.delete();
      exp_addr.delete();
      exp_data.delete();
      exp_fd.delete();
      prev_ready = 1'b1;
    end else begin
      chk("binReady", int'(binReady), int'(cyc >= ready_at));
      chk("vramWren", int'(vramWren), int'(exp_wren.exists(cyc)));
      if (exp_wren.exists(cyc)) begin
        chk("vramWriteAddr", int'(vramWriteAddr), exp_addr[cyc]);
        chk("vramInData", int'(vramInData), exp_data[cyc]);
      end
      chk("frameDone", int'(frameDone), int'(exp_fd.exists(cyc)));
      chk("overflow", int'(overflow), int'(ovf_from >= 0 && cyc >= ovf_from));

      if (vramWren) begin
        wr_addr_q.push_back(int'(vramWriteAddr));
        wr_data_q.push_back(int'(vramInData));
        wr_cyc_q.push_back(cyc);
      end
      if (frameDone) fd_count++;
      if (!prev_ready && binReady) rise_cyc = cyc;
      prev_ready = binReady;

      if (binValid && cyc >= ready_at) begin
        if (idx_m == NB) begin
          if (ovf_from < 0) ovf_from = cyc + 1;
          if (binLast) begin
            exp_fd[cyc + 1] = 1'b1;
            ready_at = cyc + 2;
            idx_m = 0;
          end
        end else begin
          int h, d, nv;
          h = bar_height(int'(binData));
          d = (peak_m[idx_m] >= 4) ? peak_m[idx_m] - 4 : 0;
          nv = (h > d) ? h : d;
          peak_m[idx_m] = nv;
          for (int k = 0; k < CPB; k++) begin
            exp_wren[cyc + 2 + k] = 1'b1;
            exp_addr[cyc + 2 + k] = idx_m * CPB + k;
            exp_data[cyc + 2 + k] = (k == CPB - 1) ? 0 : nv;
          end
          last_acc = cyc;
          if (binLast) begin
            exp_fd[cyc + 2 + CPB] = 1'b1;
            ready_at = cyc + 3 + CPB;
            idx_m = 0;
          end else begin
            ready_at = cyc + 2 + CPB;
            idx_m++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit last);
    bit got;
    got = 1'b0;
    binData = 16'(d);
    binLast = last;
    binValid = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = binReady;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got binReady=0 expected 1 within 40 cycles");
      binValid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      binValid = 1'b0;
    end
  endtask

  task automatic frame_one(input int d, input int exp, input string nm);
    int base;
    base = wr_data_q.size();
    send(d, 1'b1);
    idle(14);
    chk(nm, get_d(base), exp);
  endtask

  initial begin
    int base;
    int f0;

    // reset state
    #2 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_binReady", int'(binReady), 1);
    chk("rst_vramWren", int'(vramWren), 0);
    chk("rst_addr", int'(vramWriteAddr), 0);
    chk("rst_data", int'(vramInData), 0);
    chk("rst_frameDone", int'(frameDone), 0);
    chk("rst_overflow", int'(overflow), 0);
    rstN = 1'b1;
    idle(2);

    // single bin at idx 0: height 64, gap column at addr 9
    base = wr_addr_q.size();
    send(4096, 1'b0);
    idle(14);
    chk("single_count", wr_addr_q.size() - base, 10);
    chk("single_a0", get_a(base), 0);
    chk("single_d0", get_d(base), 64);
    chk("single_a8", get_a(base + 8), 8);
    chk("single_d8", get_d(base + 8), 64);
    chk("single_a9", get_a(base + 9), 9);
    chk("single_d9", get_d(base + 9), 0);
    chk("single_first_wr_lat", (wr_cyc_q.size() > base) ? wr_cyc_q[base] - last_acc : -1, 2);
    chk("single_ready_lat", rise_cyc - last_acc, 12);

    // clamp on bin 1, closing the frame
    base = wr_addr_q.size();
    f0 = fd_count;
    send(16'hFFFF, 1'b1);
    idle(15);
    chk("clamp_a0", get_a(base), 10);
    chk("clamp_d0", get_d(base), 511);
    chk("clamp_a9", get_a(base + 9), 19);
    chk("clamp_d9", get_d(base + 9), 0);
    chk("clamp_frameDone_pulses", fd_count - f0, 1);

    // peak-hold decay on bin 0 (peak was 64)
    frame_one(6400, 100, "decay_f1");
    frame_one(0, 96, "decay_f2");
    frame_one(0, 92, "decay_f3");
    for (int f = 0; f < 21; f++) frame_one(0, 88 - 4 * f, "decay_run");
    frame_one(1280, 20, "decay_rise");

    // full frame of 64 bins
    base = wr_addr_q.size();
    f0 = fd_count;
    for (int b = 0; b < NB; b++) send(b * 997 + 300, b == NB - 1);
    idle(15);
    chk("full_count", wr_addr_q.size() - base, 640);
    chk("full_last_addr", get_a(wr_addr_q.size() - 1), 639);
    chk("full_last_data", get_d(wr_data_q.size() - 1), 0);
    chk("full_frameDone_pulses", fd_count - f0, 1);
    base = wr_addr_q.size();
    send(4096, 1'b1);
    idle(15);
    chk("next_frame_addr", get_a(base), 0);
    chk("next_frame_data", get_d(base), 64);

    // asynchronous reset in the middle of a bar
    send(4096, 1'b0);
    idle(4);
    @(posedge clk);
    #1;
    chk("midwrite_wren_before", int'(vramWren), 1);
    #1 rstN = 1'b0;
    #1;
    chk("midwrite_wren_async", int'(vramWren), 0);
    chk("midwrite_ready_async", int'(binReady), 1);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    idle(2);

    // overflow: 65 bins without last, then a dropped last bin
    base = wr_addr_q.size();
    for (int b = 0; b < NB; b++) send(b * 500, 1'b0);
    send(1000, 1'b0);
    idle(3);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_write_count", wr_addr_q.size() - base, 640);
    f0 = fd_count;
    send(7, 1'b1);
    idle(4);
    chk("ovf_last_frameDone", fd_count - f0, 1);
    chk("ovf_last_no_write", wr_addr_q.size() - base, 640);
    base = wr_addr_q.size();
    send(4096, 1'b1);
    idle(15);
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_restart_addr", get_a(base), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
